// File: rtl/mem_ctrl_if.sv
// Bus bundle between mem_ctrl and its neighbours: the fetch stage, the MEM
// stage and the byte-wide RAM/IO bus.
//
// Handshake: a requester raises *_req_i with its command fields stable and
// keeps them until it sees the matching one-cycle *_ready_o pulse. It drops
// the request in that ready cycle. The controller samples a request only
// while idle. Read data (inst_o / mem_rdata_o) is valid in the ready cycle
// and holds until the next completion. There is no back-pressure on ready.
interface mem_ctrl_if #(
  parameter int ADDR_W = 32
);
  logic              if_req_i;
  logic [ADDR_W-1:0] if_pc_i;
  logic              if_jump_i;
  logic              inst_ready_o;
  logic [31:0]       inst_o;
  logic              is_if_output_o;
  logic              mem_req_i;
  logic              mem_wr_i;
  logic [2:0]        mem_len_i;
  logic [ADDR_W-1:0] mem_addr_i;
  logic [31:0]       mem_wdata_i;
  logic              mem_ready_o;
  logic [31:0]       mem_rdata_o;
  logic [7:0]        ram_din_i;
  logic [7:0]        ram_dout_o;
  logic [ADDR_W-1:0] ram_a_o;
  logic              ram_wr_o;
  logic              io_buffer_full_i;
  logic [1:0]        dbg_state_o;

  // Controller side
  modport slave (
    input  if_req_i, if_pc_i, if_jump_i,
    input  mem_req_i, mem_wr_i, mem_len_i, mem_addr_i, mem_wdata_i,
    input  ram_din_i, io_buffer_full_i,
    output inst_ready_o, inst_o, is_if_output_o,
    output mem_ready_o, mem_rdata_o,
    output ram_dout_o, ram_a_o, ram_wr_o,
    output dbg_state_o
  );

  // Requester / RAM side
  modport master (
    output if_req_i, if_pc_i, if_jump_i,
    output mem_req_i, mem_wr_i, mem_len_i, mem_addr_i, mem_wdata_i,
    output ram_din_i, io_buffer_full_i,
    input  inst_ready_o, inst_o, is_if_output_o,
    input  mem_ready_o, mem_rdata_o,
    input  ram_dout_o, ram_a_o, ram_wr_o,
    input  dbg_state_o
  );
endinterface

// File: rtl/mem_ctrl.sv
// Memory controller: arbitrates instruction fetch and the MEM stage onto a
// single byte-wide RAM/IO bus. Multi-byte accesses are serialised into byte
// transfers; read bytes are reassembled little-endian.
module mem_ctrl #(
  parameter int         ADDR_W     = 32,
  parameter logic [1:0] IO_MASK_HI = 2'b11
) (
  input  logic       clk,
  input  logic       rst,
  mem_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_IF_READ   = 2'd1,
    S_MEM_READ  = 2'd2,
    S_MEM_WRITE = 2'd3
  } state_t;

  state_t            r_state, w_state_nxt;
  // Reads: edges elapsed since accept. Writes: index of the byte on the bus.
  logic [2:0]        r_cnt, w_cnt_nxt;
  logic [2:0]        r_len, w_len_nxt;
  logic [ADDR_W-1:0] r_ram_a, w_ram_a_nxt;
  logic              r_ram_wr, w_ram_wr_nxt;
  logic [7:0]        r_ram_dout, w_ram_dout_nxt;
  logic [31:0]       r_buf, w_buf_nxt;       // partial read assembly
  logic [31:0]       r_wdata, w_wdata_nxt;   // remaining store bytes, LSB next
  logic              r_io, w_io_nxt;         // current write targets IO region
  logic              r_inst_ready, w_inst_ready_nxt;
  logic              r_mem_ready, w_mem_ready_nxt;
  logic [31:0]       r_inst, w_inst_nxt;
  logic [31:0]       r_rdata, w_rdata_nxt;

  logic [1:0]        w_cap_idx;
  logic [31:0]       w_buf_cap;
  logic              w_last_rd;
  logic              w_io_stall;
  logic              w_req_is_io;
  logic [2:0]        w_req_len;

  // Byte arriving on ram_din_i belongs to the address driven two edges ago
  always_comb begin
    w_cap_idx = r_cnt[1:0] - 2'd1;
    w_buf_cap = r_buf;
    w_buf_cap[{w_cap_idx, 3'b000} +: 8] = bus.ram_din_i;
    w_last_rd   = (r_cnt == r_len);
    w_io_stall  = r_io & bus.io_buffer_full_i;
    w_req_is_io = (bus.mem_addr_i[17:16] == IO_MASK_HI);
    w_req_len   = (bus.mem_len_i == 3'd0) ? 3'd1 : bus.mem_len_i;
  end

  // Next-state and next-output logic
  always_comb begin
    w_state_nxt      = r_state;
    w_cnt_nxt        = r_cnt;
    w_len_nxt        = r_len;
    w_ram_a_nxt      = r_ram_a;
    w_ram_wr_nxt     = 1'b0;
    w_ram_dout_nxt   = r_ram_dout;
    w_buf_nxt        = r_buf;
    w_wdata_nxt      = r_wdata;
    w_io_nxt         = r_io;
    w_inst_ready_nxt = 1'b0;
    w_mem_ready_nxt  = 1'b0;
    w_inst_nxt       = r_inst;
    w_rdata_nxt      = r_rdata;

    case (r_state)
      S_IDLE: begin
        // MEM stage has priority over instruction fetch
        if (bus.mem_req_i) begin
          w_state_nxt = bus.mem_wr_i ? S_MEM_WRITE : S_MEM_READ;
          w_ram_a_nxt = bus.mem_addr_i;
          w_cnt_nxt   = 3'd0;
          w_len_nxt   = w_req_len;
          w_buf_nxt   = 32'h0;
          if (bus.mem_wr_i) begin
            w_io_nxt       = w_req_is_io;
            w_ram_dout_nxt = bus.mem_wdata_i[7:0];
            w_wdata_nxt    = {8'h00, bus.mem_wdata_i[31:8]};
            w_ram_wr_nxt   = !(w_req_is_io && bus.io_buffer_full_i);
          end
        end else if (bus.if_req_i) begin
          w_state_nxt = S_IF_READ;
          w_ram_a_nxt = bus.if_pc_i;
          w_cnt_nxt   = 3'd0;
          w_len_nxt   = 3'd4;
          w_buf_nxt   = 32'h0;
        end
      end

      S_IF_READ, S_MEM_READ: begin
        if (r_state == S_IF_READ && bus.if_jump_i) begin
          // Redirected fetch: drop what was gathered so far
          w_buf_nxt = 32'h0;
          if (bus.mem_req_i) begin
            w_state_nxt = S_IDLE;
          end else begin
            w_ram_a_nxt = bus.if_pc_i;
            w_cnt_nxt   = 3'd0;
            w_len_nxt   = 3'd4;
          end
        end else begin
          if (r_cnt != 3'd0) begin
            w_buf_nxt = w_buf_cap;
          end
          if (r_cnt < r_len - 3'd1) begin
            w_ram_a_nxt = r_ram_a + 1'b1;
          end
          if (w_last_rd) begin
            w_state_nxt = S_IDLE;
            if (r_state == S_IF_READ) begin
              w_inst_nxt       = w_buf_cap;
              w_inst_ready_nxt = 1'b1;
            end else begin
              w_rdata_nxt     = w_buf_cap;
              w_mem_ready_nxt = 1'b1;
            end
          end else begin
            w_cnt_nxt = r_cnt + 3'd1;
          end
        end
      end

      S_MEM_WRITE: begin
        if (r_ram_wr) begin
          if (r_cnt == r_len - 3'd1) begin
            w_state_nxt     = S_IDLE;
            w_mem_ready_nxt = 1'b1;
          end else begin
            w_cnt_nxt      = r_cnt + 3'd1;
            w_ram_a_nxt    = r_ram_a + 1'b1;
            w_ram_dout_nxt = r_wdata[7:0];
            w_wdata_nxt    = {8'h00, r_wdata[31:8]};
            w_ram_wr_nxt   = !w_io_stall;
          end
        end else begin
          // Byte waiting on a full IO buffer: address and data held
          w_ram_wr_nxt = !w_io_stall;
        end
      end

      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= 3'd0;
      r_len        <= 3'd0;
      r_ram_a      <= '0;
      r_ram_wr     <= 1'b0;
      r_ram_dout   <= 8'h00;
      r_buf        <= 32'h0;
      r_wdata      <= 32'h0;
      r_io         <= 1'b0;
      r_inst_ready <= 1'b0;
      r_mem_ready  <= 1'b0;
      r_inst       <= 32'h0;
      r_rdata      <= 32'h0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_len        <= w_len_nxt;
      r_ram_a      <= w_ram_a_nxt;
      r_ram_wr     <= w_ram_wr_nxt;
      r_ram_dout   <= w_ram_dout_nxt;
      r_buf        <= w_buf_nxt;
      r_wdata      <= w_wdata_nxt;
      r_io         <= w_io_nxt;
      r_inst_ready <= w_inst_ready_nxt;
      r_mem_ready  <= w_mem_ready_nxt;
      r_inst       <= w_inst_nxt;
      r_rdata      <= w_rdata_nxt;
    end
  end

  // Output mapping; ownership flag is combinational on the live request
  always_comb begin
    bus.inst_ready_o   = r_inst_ready;
    bus.inst_o         = r_inst;
    bus.mem_ready_o    = r_mem_ready;
    bus.mem_rdata_o    = r_rdata;
    bus.ram_dout_o     = r_ram_dout;
    bus.ram_a_o        = r_ram_a;
    bus.ram_wr_o       = r_ram_wr;
    bus.dbg_state_o    = r_state;
    bus.is_if_output_o = (r_state == S_IF_READ) ||
                         ((r_state == S_IDLE) && !bus.mem_req_i);
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Bench for mem_ctrl: directed vector table, hand-written corner sequences
// and random transactions checked against a byte-array memory model.
module tb_mem_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  mem_ctrl_if #(.ADDR_W(32)) b ();

  mem_ctrl #(.ADDR_W(32), .IO_MASK_HI(2'b11)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (b)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- memory contents ----------------
  function automatic logic [7:0] init_byte(input logic [31:0] a);
    case (a)
      32'h0000_1000: return 8'h13;
      32'h0000_1001: return 8'h05;
      32'h0000_1002: return 8'h10;
      32'h0000_1003: return 8'h00;
      32'h0000_0020: return 8'h11;
      32'h0000_0021: return 8'h22;
      32'h0000_0022: return 8'h33;
      32'h0000_0023: return 8'h44;
      32'h0000_0040: return 8'h93;
      32'h0000_0041: return 8'h00;
      32'h0000_0042: return 8'h50;
      32'h0000_0043: return 8'h00;
      32'hFFFF_FFFE: return 8'hAA;
      32'hFFFF_FFFF: return 8'hBB;
      32'h0000_0000: return 8'hCC;
      32'h0000_0001: return 8'hDD;
      default:       return a[7:0] ^ a[15:8] ^ a[23:16] ^ a[31:24] ^ 8'h5A;
    endcase
  endfunction

  // RAM/IO device seen by the DUT (written only by the bus)
  logic [7:0]  env_mem [logic [31:0]];
  logic [31:0] wr_a_q [$];
  logic [7:0]  wr_d_q [$];

  function automatic logic [7:0] env_rd(input logic [31:0] a);
    if (env_mem.exists(a)) return env_mem[a];
    return init_byte(a);
  endfunction

  always @(posedge clk) begin
    b.ram_din_i <= env_rd(b.ram_a_o);
    if (b.ram_wr_o) begin
      env_mem[b.ram_a_o] = b.ram_dout_o;
      wr_a_q.push_back(b.ram_a_o);
      wr_d_q.push_back(b.ram_dout_o);
    end
  end

  // Reference image: what memory should hold after each store
  logic [7:0] ref_mem [logic [31:0]];

  function automatic logic [7:0] ref_rd(input logic [31:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return init_byte(a);
  endfunction

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // ---------------- driver ----------------
  // Issues one request at a negedge; lat counts negedges until the ready pulse
  // (lat = 1 is the cycle right after the accept edge).
  task automatic run_txn(input string tag, input bit is_if, input bit wr,
                         input logic [2:0] len, input logic [31:0] addr,
                         input logic [31:0] wdata, input int fc,
                         output logic [31:0] got, output int lat);
    bit seen, other;
    seen = 1'b0; other = 1'b0; got = 32'h0; lat = 0;
    if (is_if) begin
      b.if_req_i = 1'b1; b.if_pc_i = addr;
    end else begin
      b.mem_req_i = 1'b1; b.mem_wr_i = wr; b.mem_len_i = len;
      b.mem_addr_i = addr; b.mem_wdata_i = wdata;
    end
    b.io_buffer_full_i = (fc > 0);
    while (!seen && lat < 40) begin
      @(negedge clk);
      lat++;
      if (is_if ? b.mem_ready_o : b.inst_ready_o) other = 1'b1;
      if (is_if ? b.inst_ready_o : b.mem_ready_o) begin
        seen = 1'b1;
        got  = is_if ? b.inst_o : b.mem_rdata_o;
      end
      b.io_buffer_full_i = (lat < fc);
    end
    b.if_req_i = 1'b0; b.mem_req_i = 1'b0; b.io_buffer_full_i = 1'b0;
    chk({tag, "_ready_seen"}, 32'(seen), 32'd1);
    chk({tag, "_other_ready"}, 32'(other), 32'd0);
  endtask

  task automatic check_txn(input string tag, input bit wr, input logic [2:0] len,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] got, input int lat, input int ws,
                           input logic [31:0] exp_data, input int exp_lat);
    logic [31:0] a;
    chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    if (wr) begin
      chk({tag, "_nwrites"}, 32'(wr_a_q.size() - ws), 32'(len));
      for (int k = 0; k < int'(len); k++) begin
        a = addr + 32'(k);
        if (ws + k < wr_a_q.size()) begin
          chk({tag, "_wr_addr"}, wr_a_q[ws + k], a);
          chk({tag, "_wr_byte"}, 32'(wr_d_q[ws + k]), 32'(wdata[8*k +: 8]));
        end
        ref_mem[a] = wdata[8*k +: 8];
      end
    end else begin
      chk({tag, "_data"}, got, exp_data);
      chk({tag, "_nwrites"}, 32'(wr_a_q.size() - ws), 32'd0);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit          is_if;
    bit          wr;
    logic [2:0]  len;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          fc;
    logic [31:0] exp_data;
    int          exp_lat;
  } vec_t;

  vec_t vecs [12];

  initial begin
    logic [31:0] got, exp_data, addr, wdata;
    logic [2:0]  len;
    int          lat, ws, kind, fc, exp_lat;
    int          ilat, mlat;
    logic [31:0] got_i, got_m;
    bit          iseen, mseen, seen;

    b.if_req_i = 0; b.if_pc_i = 0; b.if_jump_i = 0;
    b.mem_req_i = 0; b.mem_wr_i = 0; b.mem_len_i = 0; b.mem_addr_i = 0;
    b.mem_wdata_i = 0; b.io_buffer_full_i = 0;

    //            is_if wr len  addr           wdata          fc exp_data       lat
    vecs[0]  = '{1'b1, 1'b0, 3'd4, 32'h0000_1000, 32'h0,         0, 32'h0010_0513, 6};
    vecs[1]  = '{1'b0, 1'b0, 3'd4, 32'h0000_0020, 32'h0,         0, 32'h4433_2211, 6};
    vecs[2]  = '{1'b0, 1'b0, 3'd1, 32'h0000_0021, 32'h0,         0, 32'h0000_0022, 3};
    vecs[3]  = '{1'b0, 1'b0, 3'd2, 32'h0000_0022, 32'h0,         0, 32'h0000_4433, 4};
    vecs[4]  = '{1'b0, 1'b1, 3'd2, 32'h0000_0100, 32'h0000_BEEF, 0, 32'h0,         3};
    vecs[5]  = '{1'b0, 1'b0, 3'd2, 32'h0000_0100, 32'h0,         0, 32'h0000_BEEF, 4};
    vecs[6]  = '{1'b0, 1'b1, 3'd1, 32'h0003_0000, 32'h0000_0041, 3, 32'h0,         5};
    vecs[7]  = '{1'b0, 1'b1, 3'd1, 32'h0003_0001, 32'h0000_0041, 0, 32'h0,         2};
    vecs[8]  = '{1'b0, 1'b1, 3'd4, 32'h0001_0000, 32'h1234_5678, 2, 32'h0,         5};
    vecs[9]  = '{1'b0, 1'b0, 3'd4, 32'h0001_0000, 32'h0,         2, 32'h1234_5678, 6};
    vecs[10] = '{1'b0, 1'b0, 3'd4, 32'hFFFF_FFFE, 32'h0,         0, 32'hDDCC_BBAA, 6};
    vecs[11] = '{1'b1, 1'b0, 3'd4, 32'h0000_1000, 32'h0,         0, 32'h0010_0513, 6};

    // ---- reset state ----
    repeat (3) @(negedge clk);
    chk("rst_ram_a", b.ram_a_o, 32'h0);
    chk("rst_ram_wr", 32'(b.ram_wr_o), 32'd0);
    chk("rst_ram_dout", 32'(b.ram_dout_o), 32'd0);
    chk("rst_inst", b.inst_o, 32'h0);
    chk("rst_rdata", b.mem_rdata_o, 32'h0);
    chk("rst_readies", {30'd0, b.inst_ready_o, b.mem_ready_o}, 32'd0);
    chk("rst_state", 32'(b.dbg_state_o), 32'd0);
    chk("rst_is_if_idle", 32'(b.is_if_output_o), 32'd1);
    rst = 1'b0;
    @(negedge clk);

    // ---- directed table ----
    for (int i = 0; i < 12; i++) begin
      ws = wr_a_q.size();
      run_txn($sformatf("vec%0d", i), vecs[i].is_if, vecs[i].wr, vecs[i].len,
              vecs[i].addr, vecs[i].wdata, vecs[i].fc, got, lat);
      check_txn($sformatf("vec%0d", i), vecs[i].wr, vecs[i].len, vecs[i].addr,
                vecs[i].wdata, got, lat, ws, vecs[i].exp_data, vecs[i].exp_lat);
    end
    @(negedge clk);

    // ---- IF and MEM requested together: MEM first, then IF ----
    b.mem_req_i = 1'b1; b.mem_wr_i = 1'b0; b.mem_len_i = 3'd4; b.mem_addr_i = 32'h20;
    b.if_req_i = 1'b1; b.if_pc_i = 32'h1000;
    lat = 0; iseen = 0; mseen = 0; ilat = 0; mlat = 0; got_i = 0; got_m = 0;
    while (!iseen && lat < 40) begin
      @(negedge clk);
      lat++;
      if (!mseen) chk("arb_is_if_low", 32'(b.is_if_output_o), 32'd0);
      if (lat == 7) chk("arb_is_if_high", 32'(b.is_if_output_o), 32'd1);
      if (b.inst_ready_o) begin iseen = 1; ilat = lat; got_i = b.inst_o; end
      if (b.mem_ready_o)  begin mseen = 1; mlat = lat; got_m = b.mem_rdata_o; b.mem_req_i = 1'b0; end
    end
    b.if_req_i = 1'b0; b.mem_req_i = 1'b0;
    chk("arb_mem_lat", 32'(mlat), 32'd6);
    chk("arb_mem_data", got_m, 32'h4433_2211);
    chk("arb_if_lat", 32'(ilat), 32'd12);
    chk("arb_if_data", got_i, 32'h0010_0513);
    @(negedge clk);

    // ---- fetch redirected after two bytes ----
    b.if_req_i = 1'b1; b.if_pc_i = 32'h0;
    lat = 0; seen = 0; got = 0;
    while (!seen && lat < 40) begin
      @(negedge clk);
      lat++;
      if (b.inst_ready_o) begin seen = 1; got = b.inst_o; end
      if (lat == 4) begin b.if_jump_i = 1'b1; b.if_pc_i = 32'h40; end
      if (lat == 5) begin
        b.if_jump_i = 1'b0;
        chk("abort_restart_addr", b.ram_a_o, 32'h40);
      end
    end
    b.if_req_i = 1'b0;
    chk("abort_lat", 32'(lat), 32'd10);
    chk("abort_data", got, {ref_rd(32'h43), ref_rd(32'h42), ref_rd(32'h41), ref_rd(32'h40)});
    @(negedge clk);

    // ---- reset in the middle of a 4-byte load ----
    b.mem_req_i = 1'b1; b.mem_wr_i = 1'b0; b.mem_len_i = 3'd4; b.mem_addr_i = 32'h1000;
    repeat (3) @(negedge clk);
    rst = 1'b1; b.mem_req_i = 1'b0;
    @(negedge clk);
    chk("midrst_ram_a", b.ram_a_o, 32'h0);
    chk("midrst_ram_wr", 32'(b.ram_wr_o), 32'd0);
    chk("midrst_inst", b.inst_o, 32'h0);
    chk("midrst_rdata", b.mem_rdata_o, 32'h0);
    chk("midrst_state", 32'(b.dbg_state_o), 32'd0);
    rst = 1'b0;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (b.mem_ready_o || b.inst_ready_o) seen = 1;
    end
    chk("midrst_no_ready", 32'(seen), 32'd0);
    ws = wr_a_q.size();
    run_txn("post_rst", 1'b0, 1'b0, 3'd4, 32'h20, 32'h0, 0, got, lat);
    check_txn("post_rst", 1'b0, 3'd4, 32'h20, 32'h0, got, lat, ws, 32'h4433_2211, 6);

    // ---- random transactions against the memory model ----
    for (int it = 0; it < 40; it++) begin
      kind = $urandom_range(0, 2);
      case ($urandom_range(0, 2))
        0:       len = 3'd1;
        1:       len = 3'd2;
        default: len = 3'd4;
      endcase
      case ($urandom_range(0, 3))
        0:       addr = 32'h0003_0000 + 32'($urandom_range(0, 255));
        1:       addr = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
        2:       addr = 32'h0000_2000 + 32'($urandom_range(0, 1023));
        default: addr = $urandom;
      endcase
      if (kind == 0) begin len = 3'd4; addr[1:0] = 2'b00; end
      wdata = $urandom;
      fc = $urandom_range(0, 3);
      exp_data = 32'h0;
      if (kind == 2) begin
        exp_lat = int'(len) + 1 + ((addr[17:16] == 2'b11) ? fc : 0);
      end else begin
        for (int k = 0; k < int'(len); k++)
          exp_data[8*k +: 8] = ref_rd(addr + 32'(k));
        exp_lat = int'(len) + 2;
      end
      ws = wr_a_q.size();
      run_txn($sformatf("rnd%0d", it), kind == 0, kind == 2, len, addr, wdata, fc, got, lat);
      check_txn($sformatf("rnd%0d", it), kind == 2, len, addr, wdata, got, lat, ws,
                exp_data, exp_lat);
    end

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_ctrl.md
# mem_ctrl

Memory controller that arbitrates the instruction-fetch stage and the MEM stage onto the single byte-wide RAM/IO bus. It serialises word and sub-word reads and writes into 1-byte bus transfers, reassembles read data little-endian, and returns a one-cycle ready pulse to the requester. It sits directly downstream of InstFetch, supplying instructions on i-cache misses, and beside the MEM stage.

## Interface

Parameters:
- ADDR_W, 32, address width of all ports.
- IO_MASK_HI, 2'b11, value of addr[17:16] that marks the IO region.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- if_req_i  in  1  IF read request (i-cache miss).
- if_pc_i  in  32  IF fetch address, word aligned.
- if_jump_i  in  1  PC redirected; abort or restart the IF read in flight.
- inst_ready_o  out  1  one-cycle pulse, inst_o valid.
- inst_o  out  32  fetched instruction.
- is_if_output_o  out  1  controller owned by IF, or idle with no MEM request.
- mem_req_i  in  1  MEM stage request.
- mem_wr_i  in  1  1 = store, 0 = load.
- mem_len_i  in  3  byte count: 1, 2 or 4.
- mem_addr_i  in  32  byte address.
- mem_wdata_i  in  32  store data; bytes [8k+7:8k] sent in order k = 0..len-1.
- mem_ready_o  out  1  one-cycle pulse, MEM transfer complete.
- mem_rdata_o  out  32  load data, zero-extended; MEM stage sign-extends.
- ram_din_i  in  8  byte from RAM/IO, valid the cycle after its address is sampled.
- ram_dout_o  out  8  byte to RAM/IO, registered.
- ram_a_o  out  32  bus address, registered.
- ram_wr_o  out  1  1 = write, registered.
- io_buffer_full_i  in  1  IO write buffer full.

## Operation

- States: IDLE, IF_READ, MEM_READ, MEM_WRITE. Byte counter cnt[2:0]; total len[2:0].
- Arbitration in IDLE: mem_req_i wins over if_req_i. No accept in a cycle where inst_ready_o or mem_ready_o is high.
- Accept latches the base address into ram_a_o and sets cnt = 0.
  - IF_READ: len = 4.
  - MEM_*: len = mem_len_i.
- Read: each edge advances ram_a_o by 1 while cnt < len-1. Byte k captured from ram_din_i two edges after address k is driven, into data[8k+7:8k].
- Write: byte k on ram_dout_o with ram_wr_o = 1 and ram_a_o = base+k. After the last byte, ram_wr_o = 0.
- IO stall: for a write whose addr[17:16] == IO_MASK_HI, each byte waits with ram_wr_o = 0, address held, while io_buffer_full_i = 1.
- On completion: return to IDLE, ram_wr_o = 0, pulse the matching ready for one cycle. inst_o / mem_rdata_o hold their value until the next completion.
- Abort: if_jump_i = 1 while in IF_READ.
  - Next edge discards partial data; no inst_ready_o pulse.
  - If mem_req_i = 1, go to IDLE (MEM then wins).
  - Otherwise restart IF_READ at if_pc_i.
- if_jump_i in IDLE or during MEM states has no effect.
- is_if_output_o = (state == IF_READ) | (state == IDLE & !mem_req_i). Combinational.
- Reset mid-transfer: next edge forces IDLE and discards all partial data.
- Reset values: every output 0, state IDLE.

## Timing

- Accept edge E0 puts base on ram_a_o.
- Read of N bytes:
  - Byte k is on ram_din_i after edge E(k+1) and captured at E(k+2).
  - Ready is high in the cycle after edge E(N+1): 4-byte read pulses in cycle 6 counting request cycle as 1; 1-byte read in cycle 3.
- Write of N bytes (no IO stall):
  - Byte k is on the bus in the cycle after E(k).
  - ram_wr_o drops and ready pulses in the cycle after E(N).
- Each IO-full cycle adds one cycle.
- Back-to-back: the earliest next accept is the edge ending the ready cycle.
- ram_a_o wraps modulo 2^32.

## Test plan

- IF read 0x00001000, RAM bytes 13,05,10,00 -> inst_o = 0x00100513; inst_ready_o pulse in cycle 6; ram_wr_o never 1.
- if_req_i and mem_req_i raised together, load 4 bytes at 0x20 -> MEM served first, mem_ready_o pulse; IF read starts the edge after; is_if_output_o = 0 until MEM completes.
- Store byte: len 1, 0x30000, data 0x41, io_buffer_full_i high 3 cycles -> ram_wr_o low during full; one write of 0x41 at 0x30000; ready 3 cycles later than the unstalled case.
- Store halfword 0xBEEF at 0x100 -> EF at 0x100 then BE at 0x101; mem_ready_o next cycle.
- IF read 0x0; if_jump_i pulsed after 2 bytes with if_pc_i = 0x40 -> no inst_ready_o for 0x0; new read at 0x40; pulse 6 cycles after restart edge.
- rst asserted mid 4-byte load -> next cycle all outputs 0, no ready pulse; a fresh request afterwards completes normally.
